counter_run_ctrl: RTL

- Run controller for a WIDTH-bit synchronous counter.
- Accepts a start command with a limit and a direction, then steps the count once per clock to its terminal value.
- Signals completion with a one-cycle done pulse.
- Supports pause/resume and abort.
- Sits between test/control logic and counter-driven datapaths; replaces free-running ripple counting with a sequenced, bounded run.

---
 rtl/counter_run_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
//   Sequenced run controller for a WIDTH-bit counter. A start command in IDLE
//   latches a limit and a direction. The count then steps once per clock
//   toward its terminal value: the limit when counting up, 0 when counting
//   down. Arrival at the terminal value produces a one-cycle done pulse. A
//   run can be paused (level) or aborted.
//
// Ports
//   pulse  : clock; all state changes on the rising edge
//   reset  : synchronous, active-high; overrides every other input
//   start  : begin a new run (honoured only in IDLE)
//   stop   : abort the current run (honoured in RUN and PAUSE)
//   pause  : hold the count while high (honoured in RUN and PAUSE)
//   dir    : 0 = count up 0..limit, 1 = count down limit..0 (latched at start)
//   limit  : terminal value (up) or start value (down) (latched at start)
//   count  : current count, registered
//   busy   : high in RUN and PAUSE
//   done   : high for the single cycle spent in DONE
//   state  : IDLE=00, RUN=01, PAUSE=10, DONE=11
//
// Every output is decoded from registers, so no input reaches an output
// combinationally.

module counter_run_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             pulse,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q,   dir_d;

  logic [WIDTH-1:0] term;
  logic             at_term;

  // One step toward the terminal value. The caller only steps when the count
  // is not yet terminal, so the count stays inside [0, latched limit] and
  // never wraps.
  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                  input logic             down);
    logic [WIDTH-1:0] r;
    if (down) r = c - WIDTH'(1);
    else      r = c + WIDTH'(1);
    return r;
  endfunction

  // Terminal value comes from the latched direction and limit only, so input
  // changes during a run have no effect.
  assign term    = dir_q ? '0 : limit_q;
  assign at_term = (count_q == term);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          limit_d = limit;
          dir_d   = dir;
          count_d = dir ? limit : '0;
          state_d = S_RUN;
        end
      end

      // Priority: abort, then pause, then terminal detection, then step.
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (at_term) begin
          state_d = S_DONE;
        end else begin
          count_d = step_count(count_q, dir_q);
        end
      end

      // The terminal value is not checked here. After resuming, RUN decides
      // on the next edge whether to step or to finish.
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end

      // One-cycle completion state. A start seen here is dropped, which
      // leaves exactly one IDLE cycle between back-to-back runs.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pulse) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done  = (state_q == S_DONE);

endmodule
